// File: rtl/search_engine.sv
// search_engine: probes an external synchronous-read table for a target value,
// in linear (first match) or binary (ascending unsigned table) mode.
// Optional feature macro: SEARCH_CYCLES_EN adds the 'cycles' busy-count port.
module search_engine #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [WIDTH-1:0]  target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] i
`ifdef SEARCH_CYCLES_EN
  ,
  output logic [31:0]       cycles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} state_t;

  // lo/hi carry one extra bit so lo=mid+1 past the last entry cannot wrap
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [WIDTH-1:0]    tgt_q, tgt_d;
  logic [ADDR_W:0]     lo_q, lo_d, hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W+1:0]   mid_sum;
  logic                fin, fin_found;

  // next-state: probe sequencing and result capture on entry to DONE
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tgt_d     = tgt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    found_d   = found_q;
    i_d       = i_q;
    mid_sum   = '0;
    fin       = 1'b0;
    fin_found = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          tgt_d   = target;
          lo_d    = '0;
          hi_d    = LAST;
          busy_d  = 1'b1;
          addr_d  = mode ? LAST[ADDR_W:1] : '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = CMP;
      CMP: begin
        if (mem_rdata == tgt_q) begin
          fin       = 1'b1;
          fin_found = 1'b1;
        end else if (!mode_q) begin
          if ({1'b0, addr_q} == LAST) fin = 1'b1;
          else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          if (mem_rdata < tgt_q) lo_d = {1'b0, addr_q} + 1'b1;
          else if (addr_q == '0) fin = 1'b1;
          else hi_d = {1'b0, addr_q} - 1'b1;
          if (!fin) begin
            if (lo_d > hi_d) fin = 1'b1;
            else begin
              mid_sum = {1'b0, lo_d} + {1'b0, hi_d};
              addr_d  = mid_sum[ADDR_W:1];
              state_d = FETCH;
            end
          end
        end
        if (fin) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = fin_found;
          i_d     = addr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      tgt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      i_q     <= i_d;
    end
  end

  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign i        = i_q;

`ifdef SEARCH_CYCLES_EN
  logic [31:0] cnt_q, cnt_d, cyc_q, cyc_d;

  // busy-cycle counter; result latched as the search finishes
  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if (state_q == IDLE && start) cnt_d = '0;
    else if (busy_q)              cnt_d = cnt_q + 32'd1;
    if (fin) cyc_d = cnt_d;
  end

  // counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule
